// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - PC register, next-PC select and IF/ID pipeline register
// Branch redirects take priority over stall and flush IF/ID to a single bubble.
module instr_fetch_stage #(
  parameter int unsigned                PC_WIDTH  = 64,
  parameter logic [PC_WIDTH-1:0]        RESET_PC  = '0,
  parameter int unsigned                CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 Branch,
  input  logic                 UncondBr,
  input  logic [PC_WIDTH-1:0]  br_pc,
  input  logic [25:0]          br_imm26,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic [31:0]          imem_data,
  output logic [31:0]          if_instr,
  output logic [PC_WIDTH-1:0]  if_pc,
  output logic                 if_valid,
  output logic [10:0]          opcode_Instr,
  output logic [CNT_WIDTH-1:0] redirect_cnt
);

  localparam logic [PC_WIDTH-1:0]  PC_STEP = PC_WIDTH'(4);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] imm_se;
  logic [PC_WIDTH-1:0] br_target;

  // B uses the full imm26; CBZ / B.cond carry imm19 in bits [23:5].
  always_comb begin
    imm_se = '0;
    if (UncondBr)
      imm_se = {{(PC_WIDTH-26){br_imm26[25]}}, br_imm26};
    else
      imm_se = {{(PC_WIDTH-19){br_imm26[23]}}, br_imm26[23:5]};
    br_target = br_pc + {imm_se[PC_WIDTH-3:0], 2'b00};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc           <= RESET_PC;
      if_instr     <= '0;
      if_pc        <= '0;
      if_valid     <= 1'b0;
      redirect_cnt <= '0;
    end else if (Branch) begin
      pc       <= br_target;
      if_instr <= '0;
      if_pc    <= '0;
      if_valid <= 1'b0;
      if (redirect_cnt != '1)
        redirect_cnt <= redirect_cnt + CNT_ONE;
    end else if (!stall) begin
      if_instr <= imem_data;
      if_pc    <= pc;
      if_valid <= 1'b1;
      pc       <= pc + PC_STEP;
    end
  end

  assign imem_addr    = pc;
  assign opcode_Instr = if_valid ? if_instr[31:21] : 11'h000;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - randomized self-checking bench for instr_fetch_stage
// A wide-counter and a 2-bit-counter instance share stimulus and one reference model.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, Branch, UncondBr;
  logic [63:0] br_pc;
  logic [25:0] br_imm26;
  logic [63:0] imem_addr, if_pc, imem_addr2, if_pc2;
  logic [31:0] imem_data, if_instr, imem_data2, if_instr2;
  logic        if_valid, if_valid2;
  logic [10:0] opcode_Instr, opcode_Instr2;
  logic [15:0] redirect_cnt;
  logic [1:0]  redirect_cnt2;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_instr;
  bit          m_valid;
  int          m_cnt, m_cnt2;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [63:0] a);
    if (a == 64'd0) return 32'h91000421;
    if (a == 64'd4) return 32'hAB020020;
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0000;
  endfunction

  assign imem_data  = imem_word(imem_addr);
  assign imem_data2 = imem_word(imem_addr2);

  instr_fetch_stage #(.PC_WIDTH(64), .RESET_PC(64'd0), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .Branch(Branch), .UncondBr(UncondBr),
    .br_pc(br_pc), .br_imm26(br_imm26), .imem_addr(imem_addr), .imem_data(imem_data),
    .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
    .opcode_Instr(opcode_Instr), .redirect_cnt(redirect_cnt)
  );

  instr_fetch_stage #(.PC_WIDTH(64), .RESET_PC(64'd0), .CNT_WIDTH(2)) dut_small (
    .clk(clk), .reset(reset), .stall(stall), .Branch(Branch), .UncondBr(UncondBr),
    .br_pc(br_pc), .br_imm26(br_imm26), .imem_addr(imem_addr2), .imem_data(imem_data2),
    .if_instr(if_instr2), .if_pc(if_pc2), .if_valid(if_valid2),
    .opcode_Instr(opcode_Instr2), .redirect_cnt(redirect_cnt2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [10:0] exp_op;
    exp_op = m_valid ? m_instr[31:21] : 11'h000;
    check({tag, "_addr"},   imem_addr, m_pc);
    check({tag, "_instr"},  64'(if_instr), 64'(m_instr));
    check({tag, "_ifpc"},   if_pc, m_ifpc);
    check({tag, "_valid"},  64'(if_valid), 64'(m_valid));
    check({tag, "_op"},     64'(opcode_Instr), 64'(exp_op));
    check({tag, "_cnt"},    64'(redirect_cnt), 64'(m_cnt));
    check({tag, "_addr2"},  imem_addr2, m_pc);
    check({tag, "_cnt2"},   64'(redirect_cnt2), 64'(m_cnt2));
  endtask

  task automatic model_reset();
    m_pc = 64'd0; m_ifpc = 64'd0; m_instr = 32'd0; m_valid = 1'b0;
    m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1 compare_all("rst");
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input bit s, input bit b, input bit u,
                      input logic [63:0] bp, input logic [25:0] imm);
    int unsigned raw;
    int          w;
    longint      off;
    logic [63:0] tgt;
    stall = s; Branch = b; UncondBr = u; br_pc = bp; br_imm26 = imm;
    raw = u ? 32'(imm) : 32'(imm[23:5]);
    w   = u ? 26 : 19;
    off = (raw >= (32'd1 << (w - 1))) ? longint'(raw) - (longint'(1) << w) : longint'(raw);
    tgt = bp + 64'(off * 4);
    if (b) begin
      m_pc = tgt; m_valid = 1'b0; m_instr = 32'd0; m_ifpc = 64'd0;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end else if (!s) begin
      m_instr = imem_word(m_pc); m_ifpc = m_pc; m_valid = 1'b1; m_pc = m_pc + 64'd4;
    end
    @(posedge clk); #1;
    compare_all("step");
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; Branch = 1'b0; UncondBr = 1'b0;
    br_pc = 64'd0; br_imm26 = 26'd0;
    model_reset();
    #2 compare_all("por");
    @(posedge clk); #1;
    reset = 1'b0;

    step(0, 0, 0, 64'd0, 26'd0);
    check("t1_instr", 64'(if_instr), 64'h91000421);
    check("t1_op", 64'(opcode_Instr), 64'h488);
    step(0, 0, 0, 64'd0, 26'd0);
    check("t1_op2", 64'(opcode_Instr), 64'h558);
    check("t1_addr", imem_addr, 64'h8);

    step(0, 1, 1, 64'h10, 26'h0000003);
    check("t2_pc", imem_addr, 64'h1C);
    check("t2_op", 64'(opcode_Instr), 64'h0);

    step(0, 1, 0, 64'h40, 26'h0FFFFC0);
    check("t3_pc", imem_addr, 64'h38);
    step(0, 0, 0, 64'd0, 26'd0);
    check("t3_ifpc", if_pc, 64'h38);

    step(0, 1, 1, 64'h20, 26'd0);
    step(0, 0, 0, 64'd0, 26'd0);
    step(0, 1, 1, 64'h20, 26'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 64'd0, 26'd0);
    check("t4_hold", imem_addr, 64'h20);
    step(0, 0, 0, 64'd0, 26'd0);
    check("t4_pc", imem_addr, 64'h24);

    step(1, 1, 1, 64'd0, 26'h4);
    check("t5_pc", imem_addr, 64'h10);
    check("t5_valid", 64'(if_valid), 64'd0);
    check("sat_cnt2", 64'(redirect_cnt2), 64'd3);

    step(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 26'h1);
    check("t6_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 0, 64'd0, 26'd0);
    check("t6_wrap", imem_addr, 64'd0);

    step(1, 0, 0, 64'd0, 26'd0);
    step(1, 0, 0, 64'd0, 26'd0);
    #2 do_reset();

    for (int n = 0; n < 500; n++) begin
      logic [63:0] bp;
      bit s, b, u;
      s  = ($urandom_range(0, 99) < 25);
      b  = ($urandom_range(0, 99) < 15);
      u  = 1'($urandom);
      bp = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : m_pc;
      if ($urandom_range(0, 99) == 0) begin
        #2 do_reset();
      end
      step(s, b, u, bp, 26'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
